bomba_controle: RTL and testbench
=================================

BOMBA_CONTROLE -- requirements
Module: bomba_controle

Interface
REQ-001 SHALL have parameter CODE, default 8'hA5: secret 8-bit defuse code.
REQ-002 SHALL have parameter MAX_TENT, default 3: wrong attempts allowed before detonation (1..3).
REQ-003 SHALL have parameter TEMPO_PADRAO, default 60: countdown seconds used when cfg_tempo is out of range.
REQ-004 SHALL have port clk  in  1: single system clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  in  1: reset, synchronous and active-high.
REQ-006 SHALL have port tick_1hz  in  1: one-cycle pulse, once per second.
REQ-007 SHALL have port start  in  1: one-cycle pulse that arms the bomb.
REQ-008 SHALL have port cfg_tempo  in  7: countdown length in seconds, sampled on accepted start.
REQ-009 SHALL have port codigo  in  8: code presented by the player.
REQ-010 SHALL have port confirma  in  1: one-cycle pulse that submits codigo.
REQ-011 SHALL have port armada  out  1: high while in state ARMADA.
REQ-012 SHALL have port sinalderrota  out  1: high while in state DERROTA; drives the defeat-display block.
REQ-013 SHALL have port sinalvitoria  out  1: high while in state VITORIA.
REQ-014 SHALL have port dezena  out  4: BCD tens of remaining seconds.
REQ-015 SHALL have port unidade  out  4: BCD units of remaining seconds.
REQ-016 SHALL have port tentativas  out  2: wrong attempts remaining.
REQ-017 SHALL have port bip  out  1: one-cycle pulse per countdown decrement.

Function
REQ-018 SHALL implement FSM states OCIOSA, ARMADA, VITORIA, DERROTA. Exactly one of armada/sinalvitoria/sinalderrota is high outside OCIOSA. All three are low in OCIOSA.
REQ-019 On start in OCIOSA, VITORIA or DERROTA, the block SHALL enter ARMADA on the next edge. It SHALL load the time from cfg_tempo and set tentativas=MAX_TENT. start in ARMADA SHALL be ignored.
REQ-020 cfg_tempo of 0 or >99 SHALL load TEMPO_PADRAO. A value of 1..99 SHALL be loaded as BCD (e.g. 45 -> dezena=4, unidade=5).
REQ-021 In ARMADA, each tick_1hz SHALL decrement the BCD time by 1 with borrow (unidade 0 -> 9, dezena-1) and pulse bip the same cycle.
REQ-022 A tick_1hz with time 00:01 SHALL set time to 00 and enter DERROTA on that edge.
REQ-023 In ARMADA, confirma with codigo==CODE SHALL enter VITORIA on that edge.
REQ-024 In ARMADA, confirma with codigo!=CODE SHALL decrement tentativas. If tentativas was 1, it SHALL instead set tentativas=0 and enter DERROTA.
REQ-025 If confirma and tick_1hz occur in the same cycle, confirma SHALL be evaluated first. A correct code wins even on the final tick, and the time SHALL NOT decrement. A wrong code on the last attempt means DERROTA. A wrong code otherwise means both tentativas and time decrement.
REQ-026 In VITORIA and DERROTA, time and tentativas SHALL freeze, bip SHALL stay 0, and tick_1hz and confirma SHALL be ignored.
REQ-027 tick_1hz and confirma in OCIOSA SHALL be ignored.
REQ-028 All outputs SHALL be registered, with zero combinational paths from inputs to outputs.

Reset
REQ-029 While rst is high at a clock edge, the block SHALL enter OCIOSA, including mid-countdown, with rst taking priority over all inputs.
REQ-030 Reset values SHALL be: armada=0, sinalderrota=0, sinalvitoria=0, bip=0, dezena=0, unidade=0, tentativas=MAX_TENT.

Structure
REQ-031 The FSM state encoding and the BCD width constant SHALL live in a shared package bomba_pkg, reused by display blocks.
REQ-032 The BCD down-counter (load, decrement, zero flag) SHALL be one sub-module named contador_bcd; everything else stays in bomba_controle.

Verification
REQ-033 Test: cfg_tempo=3, start, 3 ticks. Required: time 03->02->01->00, 3 bip pulses, DERROTA on the edge of the 3rd tick.
REQ-034 Test: cfg_tempo=10, start, 1 tick. Required: dezena=0, unidade=9 (borrow).
REQ-035 Test: 3 wrong confirmas (codigo=8'h00). Required: tentativas 3->2->1, then DERROTA with tentativas=0.
REQ-036 Test: time 01, confirma with 8'hA5 and tick in the same cycle. Required: VITORIA, time stays 01, no bip.
REQ-037 Test: cfg_tempo=120, start. Required: dezena=6, unidade=0. Then start in DERROTA. Required: re-arms with full time and tentativas=3.
REQ-038 Test: rst pulse mid-countdown at time 42. Required: OCIOSA next edge, all outputs at reset values, ticks ignored afterwards.

Source files
------------

// File: rtl/bomba_pkg.sv
// Shared types for the bomb game: FSM encoding and BCD helpers.
// Imported by the controller and by the display blocks.
package bomba_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    OCIOSA  = 2'd0,
    ARMADA  = 2'd1,
    VITORIA = 2'd2,
    DERROTA = 2'd3
  } estado_t;

  function automatic logic [2*BCD_W-1:0] para_bcd(
    input logic [6:0] v
  );
    return {BCD_W'(v / 7'd10), BCD_W'(v % 7'd10)};
  endfunction

endpackage

// File: rtl/contador_bcd.sv
// Two-digit BCD down-counter: parallel load, decrement with borrow,
// zero flag. Decrement saturates at 00.
module contador_bcd
  import bomba_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [2*BCD_W-1:0] valor,
  input  logic               dec,
  output logic [BCD_W-1:0]   dezena,
  output logic [BCD_W-1:0]   unidade,
  output logic               zero
);

  assign zero = (dezena == '0) && (unidade == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      dezena  <= '0;
      unidade <= '0;
    end else if (load) begin
      dezena  <= valor[2*BCD_W-1:BCD_W];
      unidade <= valor[BCD_W-1:0];
    end else if (dec && !zero) begin
      if (unidade == '0) begin
        unidade <= BCD_W'(9);
        dezena  <= dezena - BCD_W'(1);
      end else begin
        unidade <= unidade - BCD_W'(1);
      end
    end
  end

endmodule

// File: rtl/bomba_controle.sv
// Bomb game controller: arming, 1 Hz BCD countdown, code attempts
// and win/lose states.
module bomba_controle
  import bomba_pkg::*;
#(
  parameter logic [7:0] CODE         = 8'hA5,
  parameter int         MAX_TENT     = 3,
  parameter int         TEMPO_PADRAO = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       start,
  input  logic [6:0] cfg_tempo,
  input  logic [7:0] codigo,
  input  logic       confirma,
  output logic       armada,
  output logic       sinalderrota,
  output logic       sinalvitoria,
  output logic [3:0] dezena,
  output logic [3:0] unidade,
  output logic [1:0] tentativas,
  output logic       bip
);

  localparam logic [1:0] TENT_INI  = 2'(MAX_TENT);
  localparam logic [6:0] TEMPO_DEF = 7'(TEMPO_PADRAO);

  estado_t    estado, prox;
  logic [1:0] tent_prox;
  logic       carrega, decrementa, zero;
  logic       acerto, ultimo;
  logic [7:0] tempo_ini;

  assign acerto = (codigo == CODE);
  assign ultimo = (dezena == 4'd0) && (unidade == 4'd1);

  assign tempo_ini =
    (cfg_tempo == 7'd0 || cfg_tempo > 7'd99) ?
    para_bcd(TEMPO_DEF) : para_bcd(cfg_tempo);

  // A submitted code is resolved before the tick of the same cycle.
  always_comb begin
    prox       = estado;
    tent_prox  = tentativas;
    carrega    = 1'b0;
    decrementa = 1'b0;
    case (estado)
      ARMADA: begin
        if (confirma && acerto) begin
          prox = VITORIA;
        end else if (confirma && tentativas == 2'd1) begin
          tent_prox = 2'd0;
          prox      = DERROTA;
        end else begin
          if (confirma) tent_prox = tentativas - 2'd1;
          if (tick_1hz) begin
            decrementa = 1'b1;
            if (ultimo) prox = DERROTA;
          end else if (zero) begin
            prox = DERROTA;
          end
        end
      end
      default: begin
        if (start) begin
          prox      = ARMADA;
          carrega   = 1'b1;
          tent_prox = TENT_INI;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado     <= OCIOSA;
      tentativas <= TENT_INI;
      bip        <= 1'b0;
    end else begin
      estado     <= prox;
      tentativas <= tent_prox;
      bip        <= decrementa;
    end
  end

  assign armada       = (estado == ARMADA);
  assign sinalvitoria = (estado == VITORIA);
  assign sinalderrota = (estado == DERROTA);

  contador_bcd u_contador (
    .clk     (clk),
    .rst     (rst),
    .load    (carrega),
    .valor   (tempo_ini),
    .dec     (decrementa),
    .dezena  (dezena),
    .unidade (unidade),
    .zero    (zero)
  );

endmodule

// File: tb/tb_bomba_controle.sv
// Bench for bomba_controle: directed table, corner sequences and
// random traffic against a seconds/attempts reference model.
module tb_bomba_controle;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       start = 1'b0;
  logic [6:0] cfg_tempo = '0;
  logic [7:0] codigo = '0;
  logic       confirma = 1'b0;
  logic       armada, sinalderrota, sinalvitoria, bip;
  logic [3:0] dezena, unidade;
  logic [1:0] tentativas;

  bomba_controle dut (
    .clk          (clk),
    .rst          (rst),
    .tick_1hz     (tick_1hz),
    .start        (start),
    .cfg_tempo    (cfg_tempo),
    .codigo       (codigo),
    .confirma     (confirma),
    .armada       (armada),
    .sinalderrota (sinalderrota),
    .sinalvitoria (sinalvitoria),
    .dezena       (dezena),
    .unidade      (unidade),
    .tentativas   (tentativas),
    .bip          (bip)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // model: 0 idle, 1 armed, 2 won, 3 lost; time in plain seconds
  int m_st = 0;
  int m_t  = 0;
  int m_tr = 3;
  bit m_bip = 1'b0;

  typedef struct {
    logic       r, s, t, c;
    logic [7:0] cod;
    logic [6:0] cfg;
    logic       arm, vit, der;
    logic [3:0] dez, uni;
    logic [1:0] tent;
    logic       bp;
  } vec_t;

  vec_t vq[$];

  function automatic logic [13:0] saida();
    return {armada, sinalvitoria, sinalderrota,
            dezena, unidade, tentativas, bip};
  endfunction

  function automatic logic [13:0] modelo_saida();
    return {m_st == 1, m_st == 2, m_st == 3,
            4'(m_t / 10), 4'(m_t % 10), 2'(m_tr), m_bip};
  endfunction

  task automatic model_step(input bit r, s, t, c,
                            input logic [7:0] cod, input int cfg);
    m_bip = 1'b0;
    if (r) begin
      m_st = 0; m_t = 0; m_tr = 3;
    end else if (m_st == 1) begin
      if (c && cod == 8'hA5) m_st = 2;
      else if (c && m_tr == 1) begin
        m_tr = 0; m_st = 3;
      end else begin
        if (c) m_tr = m_tr - 1;
        if (t) begin
          m_t = m_t - 1; m_bip = 1'b1;
          if (m_t == 0) m_st = 3;
        end
      end
    end else if (s) begin
      m_st = 1; m_tr = 3;
      m_t = (cfg == 0 || cfg > 99) ? 60 : cfg;
    end
  endtask

  task automatic chk(input string nome, input logic [13:0] got,
                     input logic [13:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (arm,vit,der,dez,uni,tent,bip)",
               nome, got, exp);
    end
  endtask

  task automatic cyc(input bit r, s, t, c,
                     input logic [7:0] cod, input logic [6:0] cfg);
    @(negedge clk);
    rst = r; start = s; tick_1hz = t; confirma = c;
    codigo = cod; cfg_tempo = cfg;
    model_step(r, s, t, c, cod, int'(cfg));
    @(posedge clk);
    #1;
    chk("modelo", saida(), modelo_saida());
  endtask

  function automatic void add(logic r, s, t, c, logic [7:0] cod,
      logic [6:0] cfg, logic arm, vit, der, logic [3:0] dez, uni,
      logic [1:0] tent, logic bp);
    vec_t v;
    v.r = r; v.s = s; v.t = t; v.c = c; v.cod = cod; v.cfg = cfg;
    v.arm = arm; v.vit = vit; v.der = der;
    v.dez = dez; v.uni = uni; v.tent = tent; v.bp = bp;
    vq.push_back(v);
  endfunction

  task automatic expect_out(input string nome, input logic [13:0] exp);
    chk(nome, saida(), exp);
  endtask

  initial begin
    //  r s t c  cod    cfg    arm vit der dz un tn bp
    add(1,0,0,0, 8'h00, 7'd0,   0,0,0, 0,0, 3,0);
    add(0,1,0,0, 8'h00, 7'd3,   1,0,0, 0,3, 3,0);
    add(0,0,1,0, 8'h00, 7'd0,   1,0,0, 0,2, 3,1);
    add(0,0,0,0, 8'h00, 7'd0,   1,0,0, 0,2, 3,0);
    add(0,0,1,0, 8'h00, 7'd0,   1,0,0, 0,1, 3,1);
    add(0,0,1,0, 8'h00, 7'd0,   0,0,1, 0,0, 3,1);
    add(0,0,0,0, 8'h00, 7'd0,   0,0,1, 0,0, 3,0);
    add(0,1,0,0, 8'h00, 7'd10,  1,0,0, 1,0, 3,0);
    add(0,0,1,0, 8'h00, 7'd0,   1,0,0, 0,9, 3,1);
    add(0,0,0,1, 8'h00, 7'd0,   1,0,0, 0,9, 2,0);
    add(0,0,0,1, 8'h00, 7'd0,   1,0,0, 0,9, 1,0);
    add(0,0,0,1, 8'h00, 7'd0,   0,0,1, 0,9, 0,0);
    add(0,0,1,1, 8'hA5, 7'd0,   0,0,1, 0,9, 0,0);
    add(0,1,0,0, 8'h00, 7'd120, 1,0,0, 6,0, 3,0);
    add(0,1,0,0, 8'h00, 7'd5,   1,0,0, 6,0, 3,0);
    add(0,0,1,1, 8'h00, 7'd0,   1,0,0, 5,9, 2,1);
    add(0,0,0,1, 8'hA5, 7'd0,   0,1,0, 5,9, 2,0);
    add(0,0,1,1, 8'h00, 7'd0,   0,1,0, 5,9, 2,0);
    add(0,1,0,0, 8'h00, 7'd0,   1,0,0, 6,0, 3,0);
    add(0,1,0,0, 8'h00, 7'd99,  1,0,0, 6,0, 3,0);

    for (int i = 0; i < vq.size(); i++) begin
      cyc(vq[i].r, vq[i].s, vq[i].t, vq[i].c, vq[i].cod, vq[i].cfg);
      expect_out($sformatf("tabela%0d", i),
        {vq[i].arm, vq[i].vit, vq[i].der, vq[i].dez, vq[i].uni,
         vq[i].tent, vq[i].bp});
    end

    // correct code on the final tick wins without decrementing
    cyc(1, 0, 0, 0, 8'h00, 7'd0);
    cyc(0, 1, 0, 0, 8'h00, 7'd1);
    expect_out("arma_01", {3'b100, 4'd0, 4'd1, 2'd3, 1'b0});
    cyc(0, 0, 1, 1, 8'hA5, 7'd0);
    expect_out("acerto_ultimo_tick", {3'b010, 4'd0, 4'd1, 2'd3, 1'b0});

    // wrong code on the last attempt together with a tick
    cyc(0, 1, 0, 0, 8'h00, 7'd20);
    cyc(0, 0, 0, 1, 8'h11, 7'd0);
    cyc(0, 0, 0, 1, 8'h22, 7'd0);
    cyc(0, 0, 1, 1, 8'h33, 7'd0);
    expect_out("erro_ultima_tent", {3'b001, 4'd2, 4'd0, 2'd0, 1'b0});

    // reset mid-countdown at 42
    cyc(0, 1, 0, 0, 8'h00, 7'd42);
    expect_out("arma_42", {3'b100, 4'd4, 4'd2, 2'd3, 1'b0});
    cyc(0, 0, 0, 1, 8'h00, 7'd0);
    cyc(1, 0, 1, 1, 8'hA5, 7'd0);
    expect_out("reset_meio", {3'b000, 4'd0, 4'd0, 2'd3, 1'b0});
    cyc(0, 0, 1, 0, 8'h00, 7'd0);
    cyc(0, 0, 1, 1, 8'hA5, 7'd0);
    expect_out("ocioso_ignora", {3'b000, 4'd0, 4'd0, 2'd3, 1'b0});

    for (int i = 0; i < 3000; i++) begin
      bit r, s, t, c;
      logic [7:0] cod;
      r = ($urandom_range(0, 199) == 0);
      s = ($urandom_range(0, 14) == 0);
      t = ($urandom_range(0, 2) == 0);
      c = ($urandom_range(0, 5) == 0);
      cod = ($urandom_range(0, 2) == 0) ? 8'hA5 : 8'($urandom);
      cyc(r, s, t, c, cod, 7'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
